// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared register-file defaults and index/data types
// Revision: 1.0
// ============================================================================
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : per-register busy bits, claim/clear, claim_err, any_busy
// Optional macro WRITE_BYPASS_EN forwards same-cycle writeback clears to busy_a/b.
// Revision: 1.0
// ============================================================================
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wreg,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  input  logic [ADDR_W-1:0] rega,
  input  logic [ADDR_W-1:0] regb,
  output logic              busy_a,
  output logic              busy_b,
  output logic              any_busy,
  output logic              claim_err
);
  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] busy_q, busy_d;
  logic             claim_err_q, claim_err_d;

  // Claim is applied after the writeback clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (write_en) busy_d[wreg] = 1'b0;
    if (claim_en) busy_d[claim_reg] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
    claim_err_d = claim_en && busy_q[claim_reg];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      claim_err_q <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      claim_err_q <= claim_err_d;
    end
  end

  function automatic logic port_busy(input logic [ADDR_W-1:0] idx);
    logic b;
    b = busy_q[idx];
`ifdef WRITE_BYPASS_EN
    if (write_en && (wreg == idx)) b = claim_en && (claim_reg == idx);
`endif
    if (ZERO_REG && (idx == '0)) b = 1'b0;
    if (!rst_n) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    busy_a = port_busy(rega);
    busy_b = port_busy(regb);
  end

  assign any_busy  = |busy_q;
  assign claim_err = claim_err_q;
endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : parametrised 2R/1W register file with writeback scoreboard
// Optional macro WRITE_BYPASS_EN forwards writedata to same-cycle reads.
// Revision: 1.0
// ============================================================================
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wreg,
  input  logic [DATA_W-1:0] writedata,
  input  logic [ADDR_W-1:0] rega,
  input  logic [ADDR_W-1:0] regb,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  output logic              busy_a,
  output logic              busy_b,
  output logic              any_busy,
  output logic              claim_err
);
  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_ok;

  assign wr_ok = write_en && !(ZERO_REG && (wreg == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wreg] <= writedata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = regs_q[idx];
`ifdef WRITE_BYPASS_EN
    if (write_en && (wreg == idx)) v = writedata;
`endif
    if (ZERO_REG && (idx == '0)) v = '0;
    if (!rst_n) v = '0;
    return v;
  endfunction

  always_comb begin
    read1 = read_port(rega);
    read2 = read_port(regb);
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .write_en  (write_en),
    .wreg      (wreg),
    .claim_en  (claim_en),
    .claim_reg (claim_reg),
    .rega      (rega),
    .regb      (regb),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .any_busy  (any_busy),
    .claim_err (claim_err)
  );
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : scoreboard bench for regfile_sb, ZERO_REG=0 and ZERO_REG=1 side by side
// Revision: 1.0
// ============================================================================
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_en;
  logic [2:0]  wreg;
  logic [15:0] writedata;
  logic [2:0]  rega, regb;
  logic        claim_en;
  logic [2:0]  claim_reg;

  logic [15:0] read1 [2];
  logic [15:0] read2 [2];
  logic        busy_a [2];
  logic        busy_b [2];
  logic        any_busy [2];
  logic        claim_err [2];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rega(rega), .regb(regb), .read1(read1[0]), .read2(read2[0]),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy_a(busy_a[0]), .busy_b(busy_b[0]),
    .any_busy(any_busy[0]), .claim_err(claim_err[0])
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rega(rega), .regb(regb), .read1(read1[1]), .read2(read2[1]),
    .claim_en(claim_en), .claim_reg(claim_reg), .busy_a(busy_a[1]), .busy_b(busy_b[1]),
    .any_busy(any_busy[1]), .claim_err(claim_err[1])
  );

  typedef struct packed {
    logic [1:0][15:0] r1;
    logic [1:0][15:0] r2;
    logic [1:0]       ba;
    logic [1:0]       bb;
    logic [1:0]       ab;
    logic [1:0]       ce;
  } exp_t;

  typedef struct packed {
    logic        b;
    logic [15:0] v;
  } view_t;

  exp_t expq [$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: index 1 is the hardwired-zero variant, where r0 simply never changes.
  logic [15:0] m_regs [2][8];
  logic        m_busy [2][8];
  logic        m_err  [2];

  function automatic void model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[z][i] = 16'h0;
        m_busy[z][i] = 1'b0;
      end
      m_err[z] = 1'b0;
    end
  endfunction

  function automatic view_t view(input int z, input logic [2:0] idx);
    view_t r;
    r.v = m_regs[z][idx];
    r.b = m_busy[z][idx];
`ifdef WRITE_BYPASS_EN
    if (write_en && wreg == idx) begin
      r.v = writedata;
      r.b = claim_en && claim_reg == idx;
    end
`endif
    if (z == 1 && idx == 3'd0) r = '0;
    if (!rst_n) r = '0;
    return r;
  endfunction

  function automatic exp_t predict();
    exp_t  e;
    view_t va, vb;
    e = '0;
    for (int z = 0; z < 2; z++) begin
      va = view(z, rega);
      vb = view(z, regb);
      e.r1[z] = va.v;
      e.r2[z] = vb.v;
      e.ba[z] = va.b;
      e.bb[z] = vb.b;
      e.ab[z] = 1'b0;
      for (int i = 0; i < 8; i++) if (m_busy[z][i]) e.ab[z] = 1'b1;
      e.ce[z] = m_err[z];
    end
    return e;
  endfunction

  function automatic void model_edge();
    logic err;
    if (!rst_n) return;
    for (int z = 0; z < 2; z++) begin
      err = claim_en && m_busy[z][claim_reg];
      if (write_en && !(z == 1 && wreg == 3'd0)) begin
        m_regs[z][wreg] = writedata;
        m_busy[z][wreg] = 1'b0;
      end
      if (claim_en && !(z == 1 && claim_reg == 3'd0)) m_busy[z][claim_reg] = 1'b1;
      m_err[z] = err;
    end
  endfunction

  function automatic void check(input string name, input int z,
                                input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] t=%0t got %h expected %h", name, z, $time, act, exp);
    end
  endfunction

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        for (int z = 0; z < 2; z++) begin
          check("read1", z, read1[z], e.r1[z]);
          check("read2", z, read2[z], e.r2[z]);
          check("busy_a", z, 16'(busy_a[z]), 16'(e.ba[z]));
          check("busy_b", z, 16'(busy_b[z]), 16'(e.bb[z]));
          check("any_busy", z, 16'(any_busy[z]), 16'(e.ab[z]));
          check("claim_err", z, 16'(claim_err[z]), 16'(e.ce[z]));
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic ce, input logic [2:0] cr);
    write_en = we; wreg = wr; writedata = wd;
    rega = ra; regb = rb; claim_en = ce; claim_reg = cr;
  endtask

  task automatic cycle(input logic we, input logic [2:0] wr, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic ce, input logic [2:0] cr);
    drive(we, wr, wd, ra, rb, ce, cr);
    expq.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Drops rst_n between edges with claims and a write in flight, holds two cycles, releases mid-cycle.
  task automatic reset_mid();
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 3'd6, 16'hBEEF, 3'd6, 3'd1, 1'b1, 3'd6);
      expq.push_back(predict());
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 3'd0);
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b1, 3'd2, 16'h1111, 3'd2, 3'd5, 1'b1, 3'd2);
    cycle(1'b0, 3'd0, 16'h0, 3'd7, 3'd4, 1'b0, 3'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) cycle(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, 3'd0);

    cycle(1'b1, 3'd3, 16'h00A5, 3'd3, 3'd3, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd3, 3'd3, 1'b0, 3'd0);

    cycle(1'b0, 3'd0, 16'h0,    3'd5, 3'd3, 1'b1, 3'd5);
    cycle(1'b0, 3'd0, 16'h0,    3'd5, 3'd3, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd5, 3'd3, 1'b0, 3'd0);
    cycle(1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd5, 3'd5, 1'b0, 3'd0);

    cycle(1'b1, 3'd2, 16'h0007, 3'd2, 3'd2, 1'b1, 3'd2);
    cycle(1'b0, 3'd0, 16'h0,    3'd2, 3'd2, 1'b1, 3'd2);
    cycle(1'b0, 3'd0, 16'h0,    3'd2, 3'd2, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd2, 3'd2, 1'b0, 3'd0);

    cycle(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 1'b1, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd0, 3'd0, 1'b1, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd0, 3'd0, 1'b0, 3'd0);

    cycle(1'b0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b1, 3'd1);
    cycle(1'b0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b1, 3'd6);
    reset_mid();
    cycle(1'b0, 3'd0, 16'h0,    3'd1, 3'd6, 1'b0, 3'd0);
    cycle(1'b1, 3'd6, 16'h5A5A, 3'd6, 3'd1, 1'b0, 3'd0);
    cycle(1'b0, 3'd0, 16'h0,    3'd6, 3'd1, 1'b0, 3'd0);

    for (int n = 0; n < 400; n++) begin
      logic       we, ce;
      logic [2:0] wr, ra, rb, cr;
      we = 1'($urandom_range(0, 1));
      wr = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 2) == 0) ? wr : 3'($urandom_range(0, 7));
      rb = ($urandom_range(0, 2) == 0) ? wr : 3'($urandom_range(0, 7));
      ce = ($urandom_range(0, 2) == 0);
      cr = ($urandom_range(0, 3) == 0) ? wr : 3'($urandom_range(0, 7));
      cycle(we, wr, 16'($urandom), ra, rb, ce, cr);
    end
    cycle(1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b0, 3'd0);

    for (int k = 0; k < 5 && expq.size() > 0; k++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
